// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// Decode / operand-fetch stage feeding the 64-bit ALU. Accepts one LEGv8
// instruction per valid/ready handshake, reads the locally owned 32-entry
// register file (with write-back bypass and a hardwired zero register) and
// presents the decoded operand bundle from a single-entry output buffer.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake, instr = instruction word
//   wb_en/wb_addr/wb_data register-file write port
//   flush                 drops the buffered bundle and any capture this cycle
//   out_valid/out_ready   downstream handshake
//   data1, data2, alu_op  ALU operands and operation (00 add 01 sub 10 and 11 or)
//   store_data, rd        X[Rt] for stores, destination register
//   reg_write, mem_read, mem_write, branch_zero, illegal  control bits
module alu_operand_stage #(
  parameter int DATA_W   = 64,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] store_data,
  output logic [4:0]        rd,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch_zero,
  output logic              illegal
);

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  typedef enum logic [3:0] {
    CLS_ADD, CLS_SUB, CLS_AND, CLS_ORR,
    CLS_ADDI, CLS_SUBI, CLS_LDUR, CLS_STUR,
    CLS_CBZ, CLS_ILLEGAL
  } instr_class_e;

  logic [DATA_W-1:0] regs [32];
  logic [4:0]        rn_idx, rm_idx, rt_idx;
  logic [DATA_W-1:0] rn_val, rm_val, rt_val;
  instr_class_e      cls;
  logic              capture;

  logic [DATA_W-1:0] nxt_data1, nxt_data2, nxt_store_data;
  logic [1:0]        nxt_alu_op;
  logic [4:0]        nxt_rd;
  logic              nxt_reg_write, nxt_mem_read, nxt_mem_write;
  logic              nxt_branch_zero, nxt_illegal;

  assign rn_idx   = instr[9:5];
  assign rm_idx   = instr[20:16];
  assign rt_idx   = instr[4:0];
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Register file: writes commit at the edge and are independent of the
  // handshake and of flush. The zero register is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != ZR) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Read ports with write-back bypass so an instruction captured in the same
  // cycle as a write sees the new value. The zero-register check comes last
  // so it overrides both the array and the bypass.
  always_comb begin
    rn_val = regs[rn_idx];
    rm_val = regs[rm_idx];
    rt_val = regs[rt_idx];
    if (wb_en && wb_addr == rn_idx) rn_val = wb_data;
    if (wb_en && wb_addr == rm_idx) rm_val = wb_data;
    if (wb_en && wb_addr == rt_idx) rt_val = wb_data;
    if (rn_idx == ZR) rn_val = '0;
    if (rm_idx == ZR) rm_val = '0;
    if (rt_idx == ZR) rt_val = '0;
  end

  // Opcode classification. Longer opcodes are tested before the 8-bit CBZ
  // opcode; the encodings do not overlap so the order is only for clarity.
  always_comb begin
    cls = CLS_ILLEGAL;
    if      (instr[31:21] == 11'b10001011000) cls = CLS_ADD;
    else if (instr[31:21] == 11'b11001011000) cls = CLS_SUB;
    else if (instr[31:21] == 11'b10001010000) cls = CLS_AND;
    else if (instr[31:21] == 11'b10101010000) cls = CLS_ORR;
    else if (instr[31:22] == 10'b1001000100)  cls = CLS_ADDI;
    else if (instr[31:22] == 10'b1101000100)  cls = CLS_SUBI;
    else if (instr[31:21] == 11'b11111000010) cls = CLS_LDUR;
    else if (instr[31:21] == 11'b11111000000) cls = CLS_STUR;
    else if (instr[31:24] == 8'b10110100)     cls = CLS_CBZ;
  end

  // Bundle formation. Defaults describe the illegal case (everything zero),
  // each legal class then fills in only what it uses.
  always_comb begin
    nxt_data1       = '0;
    nxt_data2       = '0;
    nxt_store_data  = '0;
    nxt_alu_op      = 2'b00;
    nxt_rd          = '0;
    nxt_reg_write   = 1'b0;
    nxt_mem_read    = 1'b0;
    nxt_mem_write   = 1'b0;
    nxt_branch_zero = 1'b0;
    nxt_illegal     = 1'b0;
    case (cls)
      CLS_ADD, CLS_SUB, CLS_AND, CLS_ORR: begin
        nxt_data1     = rn_val;
        nxt_data2     = rm_val;
        nxt_rd        = rt_idx;
        nxt_reg_write = 1'b1;
        nxt_alu_op    = (cls == CLS_SUB) ? 2'b01 :
                        (cls == CLS_AND) ? 2'b10 :
                        (cls == CLS_ORR) ? 2'b11 : 2'b00;
      end
      CLS_ADDI, CLS_SUBI: begin
        nxt_data1     = rn_val;
        nxt_data2     = {{(DATA_W-12){1'b0}}, instr[21:10]};
        nxt_rd        = rt_idx;
        nxt_reg_write = 1'b1;
        nxt_alu_op    = (cls == CLS_SUBI) ? 2'b01 : 2'b00;
      end
      CLS_LDUR: begin
        nxt_data1     = rn_val;
        nxt_data2     = {{(DATA_W-9){instr[20]}}, instr[20:12]};
        nxt_rd        = rt_idx;
        nxt_mem_read  = 1'b1;
        nxt_reg_write = 1'b1;
      end
      CLS_STUR: begin
        nxt_data1      = rn_val;
        nxt_data2      = {{(DATA_W-9){instr[20]}}, instr[20:12]};
        nxt_store_data = rt_val;
        nxt_rd         = rt_idx;
        nxt_mem_write  = 1'b1;
      end
      CLS_CBZ: begin
        nxt_data2       = rt_val;
        nxt_rd          = rt_idx;
        nxt_branch_zero = 1'b1;
      end
      default: nxt_illegal = 1'b1;
    endcase
  end

  // Single-entry output buffer. Flush wins over everything; a capture
  // replaces the bundle (also when the old one is consumed in the same
  // cycle); a consume without capture only clears out_valid so the bundle
  // fields keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      data1       <= '0;
      data2       <= '0;
      store_data  <= '0;
      alu_op      <= 2'b00;
      rd          <= '0;
      reg_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      branch_zero <= 1'b0;
      illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      data1       <= nxt_data1;
      data2       <= nxt_data2;
      store_data  <= nxt_store_data;
      alu_op      <= nxt_alu_op;
      rd          <= nxt_rd;
      reg_write   <= nxt_reg_write;
      mem_read    <= nxt_mem_read;
      mem_write   <= nxt_mem_write;
      branch_zero <= nxt_branch_zero;
      illegal     <= nxt_illegal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Decode/operand-fetch stage that sits directly upstream of the 64-bit ALU. It accepts one 32-bit LEGv8 instruction per handshake and reads the 32x64 register file, which it owns. It registers `data1`, `data2` and `alu_op` plus control bits for the execute stage, behind a single-entry valid/ready output buffer with flush.

## Interface
Parameters:
- `DATA_W`, default 64: register and operand width.
- `ZERO_REG`, default 31: index of the hardwired zero register (XZR).

Ports:
- `clk`, input, 1: sole clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: `instr` is valid.
- `in_ready`, output, 1: the stage can accept `instr` this cycle.
- `instr`, input, 32: LEGv8 instruction word.
- `wb_en`, input, 1: register-file write enable.
- `wb_addr`, input, 5: write index.
- `wb_data`, input, DATA_W: write data.
- `flush`, input, 1: discard the buffered entry and any capture in the same cycle.
- `out_valid`, output, 1: the output bundle is valid.
- `out_ready`, input, 1: downstream consumes the bundle.
- `data1`, output, DATA_W: ALU operand A.
- `data2`, output, DATA_W: ALU operand B.
- `alu_op`, output, 2: encoded as 00 add, 01 sub, 10 and, 11 or.
- `store_data`, output, DATA_W: X[Rt] for STUR.
- `rd`, output, 5: destination register.
- `reg_write`, output, 1: write-back control bit.
- `mem_read`, output, 1: memory read control bit.
- `mem_write`, output, 1: memory write control bit.
- `branch_zero`, output, 1: CBZ control bit.
- `illegal`, output, 1: unrecognised opcode.

## Operation
Field positions: Rm=[20:16], Rn=[9:5], Rd/Rt=[4:0].

Decode, by opcode:
- **ADD** (`[31:21]`=10001011000): data1=X[Rn], data2=X[Rm], alu_op=00, reg_write=1.
- **SUB** (`[31:21]`=11001011000): as ADD, with alu_op=01.
- **AND** (`[31:21]`=10001010000): as ADD, with alu_op=10.
- **ORR** (`[31:21]`=10101010000): as ADD, with alu_op=11.
- **ADDI** (`[31:22]`=1001000100): data2 = `[21:10]` zero-extended to DATA_W, alu_op=00, reg_write=1.
- **SUBI** (`[31:22]`=1101000100): as ADDI, with alu_op=01.
- **LDUR** (`[31:21]`=11111000010): data1=X[Rn], data2 = `[20:12]` sign-extended, alu_op=00, mem_read=1, reg_write=1.
- **STUR** (`[31:21]`=11111000000): as LDUR but mem_write=1, reg_write=0, store_data=X[Rt].
- **CBZ** (`[31:24]`=10110100): data1=0, data2=X[Rt], alu_op=00, branch_zero=1.
- **Anything else**: illegal=1. All control bits 0, data1=data2=store_data=0, alu_op=00, rd=0.

Register file:
- 32 entries of DATA_W bits.
- Reads of ZERO_REG return 0. Writes to ZERO_REG are ignored.
- Write bypass: if `wb_en` and `wb_addr` equals a read index (≠ZERO_REG) in the capture cycle, the read returns `wb_data`.

Handshake:
- `in_ready = !out_valid || out_ready` (combinational).
- Capture occurs when `in_valid && in_ready && !flush`. The next edge loads the bundle and sets `out_valid`=1.
- `out_valid && out_ready` with no capture clears `out_valid`.
- While `out_valid && !out_ready`, the bundle holds stable.
- `flush`=1 clears `out_valid` at the edge and suppresses any capture in that cycle. Register-file writes still occur.
- Outputs that are not cleared keep their last value when `out_valid`=0.

## Timing
- Reset (asynchronous, active-low) forces:
  - `out_valid`=0 and all bundle outputs to 0.
  - All 32 registers to 0.
  - `in_ready`=1 after reset releases.
- Latency is 1 cycle: an instruction captured at edge N is presented from edge N on, with `out_valid`=1.
- Throughput is one instruction per cycle while `out_ready`=1.
- Register-file writes commit at the edge.
- Assertion of `rst_n`=0 mid-stream drops the buffered bundle immediately, without waiting for a clock edge.
- Simultaneous consume and capture: the bundle is replaced and `out_valid` stays 1.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream.
  - Required: `out_valid`=0 immediately, and ADD X1,X2,X3 then yields data1=data2=0.
- **Bypass:** write X2=0x10 and X3=0x5 via `wb`, then issue SUB X1,X2,X3 while simultaneously writing X3=0x7.
  - Required: data1=0x10, data2=0x7, alu_op=01, rd=1, reg_write=1.
- **Immediate extension:**
  - LDUR X4,[X2,#-8] -> data2=0xFFFFFFFFFFFFFFF8, mem_read=1.
  - ADDI imm 0xFFF -> data2=0xFFF.
- **Zero register and CBZ:**
  - Write X31=0xFF, then ORR X1,X31,X31 -> data1=data2=0.
  - CBZ X5 with X5=0 -> branch_zero=1, data2=0.
- **Backpressure:** hold `out_ready`=0 for 3 cycles with `in_valid`=1.
  - Required: `in_ready`=0, the bundle is stable, and the next instruction is captured the cycle `out_ready` rises.
  - Required: back-to-back streaming with no bubbles once `out_ready`=1.
- **Flush and illegal:**
  - `flush` together with a capture -> `out_valid`=0 next cycle.
  - `instr`=0x00000000 -> illegal=1, all control bits 0.
